// File: rtl/pix_clk_frac_gen.sv
// Pixel-rate tick and square-wave clock from the system clock, using either an
// integer divider or a phase accumulator, with shadowed glitch-free reconfiguration.
module pix_clk_frac_gen #(
    parameter int unsigned     ACC_W        = 32,
    parameter int unsigned     DIV_W        = 16,
    parameter bit              DEFAULT_MODE = 1'b1,
    parameter int unsigned     DEFAULT_DIV  = 4,
    parameter longint unsigned DEFAULT_INC  = 64'd1081258017,
    parameter int unsigned     LOCK_TICKS   = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_load,
    input  logic             cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [ACC_W-1:0] cfg_inc,
    output logic             cfg_busy,
    output logic             pix_tick,
    output logic             clk_pix,
    output logic             locked
);
    localparam int unsigned      LC_W    = $clog2(LOCK_TICKS + 1);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [ACC_W-1:0] DEF_INC = ACC_W'(DEFAULT_INC);
    localparam logic [LC_W-1:0]  LOCK_N  = LC_W'(LOCK_TICKS);

    logic             mode_q, mode_d, sh_mode_q, sh_mode_d;
    logic [DIV_W-1:0] div_q, div_d, sh_div_q, sh_div_d;
    logic [ACC_W-1:0] inc_q, inc_d, sh_inc_q, sh_inc_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LC_W-1:0]  lcnt_q, lcnt_d;
    logic             busy_q, busy_d;
    logic             tick_q, tick_d;
    logic             clkp_q, clkp_d;
    logic             lock_q, lock_d;

    logic [DIV_W-1:0] dv, cnt_nx;
    logic [DIV_W:0]   half;
    logic [ACC_W:0]   sum;
    logic             wrap, tick_n, clkp_n, apply;

    // Period position and phase for the active configuration
    always_comb begin
        dv     = (div_q == '0) ? DIV_W'(1) : div_q;
        wrap   = (cnt_q == dv - DIV_W'(1));
        cnt_nx = wrap ? '0 : cnt_q + DIV_W'(1);
        half   = ({1'b0, dv} + (DIV_W+1)'(1)) >> 1;
        sum    = {1'b0, acc_q} + {1'b0, inc_q};
        if (mode_q) begin
            tick_n = sum[ACC_W];
            clkp_n = sum[ACC_W-1];
        end else begin
            tick_n = wrap;
            clkp_n = ({1'b0, cnt_nx} < half);
        end
        apply = busy_q && (!en || tick_n);
    end

    always_comb begin
        mode_d    = mode_q;
        div_d     = div_q;
        inc_d     = inc_q;
        sh_mode_d = sh_mode_q;
        sh_div_d  = sh_div_q;
        sh_inc_d  = sh_inc_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        lcnt_d    = lcnt_q;
        busy_d    = busy_q;
        tick_d    = 1'b0;
        clkp_d    = 1'b0;
        if (en) begin
            tick_d = tick_n;
            clkp_d = clkp_n;
            if (mode_q) acc_d = sum[ACC_W-1:0];
            else        cnt_d = cnt_nx;
            if (tick_n && lcnt_q != LOCK_N) lcnt_d = lcnt_q + LC_W'(1);
        end else begin
            lcnt_d = '0;
        end
        // Boundary tick is still emitted; the new config starts from phase 0
        if (apply) begin
            mode_d = sh_mode_q;
            div_d  = sh_div_q;
            inc_d  = sh_inc_q;
            cnt_d  = '0;
            acc_d  = '0;
            lcnt_d = '0;
            busy_d = 1'b0;
        end
        if (cfg_load) begin
            sh_mode_d = cfg_mode;
            sh_div_d  = cfg_div;
            sh_inc_d  = cfg_inc;
            busy_d    = 1'b1;
        end
        lock_d = (lcnt_d == LOCK_N) && !busy_d;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mode_q    <= DEFAULT_MODE;
            div_q     <= DEF_DIV;
            inc_q     <= DEF_INC;
            sh_mode_q <= DEFAULT_MODE;
            sh_div_q  <= DEF_DIV;
            sh_inc_q  <= DEF_INC;
            cnt_q     <= '0;
            acc_q     <= '0;
            lcnt_q    <= '0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            clkp_q    <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            div_q     <= div_d;
            inc_q     <= inc_d;
            sh_mode_q <= sh_mode_d;
            sh_div_q  <= sh_div_d;
            sh_inc_q  <= sh_inc_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            lcnt_q    <= lcnt_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
            clkp_q    <= clkp_d;
            lock_q    <= lock_d;
        end
    end

    assign cfg_busy = busy_q;
    assign pix_tick = tick_q;
    assign clk_pix  = clkp_q;
    assign locked   = lock_q;
endmodule

// File: tb/tb_pix_clk_frac_gen.sv
// Directed bench for pix_clk_frac_gen: a cycle model pushes expected outputs
// to a scoreboard before each edge; they are popped and compared after it.
module tb_pix_clk_frac_gen;
    localparam int ACC_W = 32;
    localparam int DIV_W = 16;
    localparam longint unsigned DINC = 64'd1081258017;

    logic             clk_in   = 1'b0;
    logic             reset    = 1'b1;
    logic             en       = 1'b0;
    logic             cfg_load = 1'b0;
    logic             cfg_mode = 1'b0;
    logic [DIV_W-1:0] cfg_div  = '0;
    logic [ACC_W-1:0] cfg_inc  = '0;
    logic             cfg_busy, pix_tick, clk_pix, locked;

    pix_clk_frac_gen dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (en),
        .cfg_load (cfg_load),
        .cfg_mode (cfg_mode),
        .cfg_div  (cfg_div),
        .cfg_inc  (cfg_inc),
        .cfg_busy (cfg_busy),
        .pix_tick (pix_tick),
        .clk_pix  (clk_pix),
        .locked   (locked)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic tick;
        logic clk;
        logic busy;
        logic lock;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit              m_mode, s_mode, m_busy;
    int unsigned     m_div, s_div, m_cnt, m_lc;
    longint unsigned m_inc, s_inc, m_acc;

    int  cyc = 0;
    int  last_tick = 0;
    int  min_gap = 1000;
    int  tick_cnt = 0;
    bit  saw5 = 1'b0;
    longint unsigned ref_cnt;

    function automatic void model_reset();
        m_mode = 1'b1; s_mode = 1'b1;
        m_div  = 4;    s_div  = 4;
        m_inc  = DINC; s_inc  = DINC;
        m_acc  = 0;    m_cnt  = 0;
        m_busy = 1'b0; m_lc   = 0;
    endfunction

    // Predict the outputs that follow the next edge from the current inputs
    task automatic model_push();
        int unsigned     d, pos;
        longint unsigned s;
        bit              t, c, ap;
        exp_t            e;
        d   = (m_div == 0) ? 1 : m_div;
        s   = 0;
        pos = 0;
        if (m_mode) begin
            s = m_acc + m_inc;
            t = s[32];
            c = s[31];
        end else begin
            pos = (m_cnt + 1) % d;
            t   = (pos == 0);
            c   = (pos < (d + 1) / 2);
        end
        ap = m_busy && (!en || t);
        if (en) begin
            if (m_mode) m_acc = s & 64'hFFFF_FFFF;
            else        m_cnt = pos;
            if (t) m_lc++;
        end else begin
            m_lc = 0;
        end
        if (ap) begin
            m_mode = s_mode; m_div = s_div; m_inc = s_inc;
            m_acc = 0; m_cnt = 0; m_busy = 1'b0; m_lc = 0;
        end
        if (cfg_load) begin
            s_mode = cfg_mode; s_div = cfg_div; s_inc = cfg_inc;
            m_busy = 1'b1;
        end
        e.tick = en && t;
        e.clk  = en && c;
        e.busy = m_busy;
        e.lock = en && !m_busy && (m_lc >= 16);
        sb.push_back(e);
    endtask

    task automatic pop_check(string tag);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty at cyc %0d", tag, cyc);
            return;
        end
        e = sb.pop_front();
        checks += 3;
        assert (pix_tick === e.tick) else begin
            errors++;
            $error("FAIL %s pix_tick: got %b exp %b cyc %0d", tag, pix_tick, e.tick, cyc);
        end
        assert (clk_pix === e.clk) else begin
            errors++;
            $error("FAIL %s clk_pix: got %b exp %b cyc %0d", tag, clk_pix, e.clk, cyc);
        end
        assert (cfg_busy === e.busy) else begin
            errors++;
            $error("FAIL %s cfg_busy: got %b exp %b cyc %0d", tag, cfg_busy, e.busy, cyc);
        end
        assert (locked === e.lock) else begin
            errors++;
            $error("FAIL %s locked: got %b exp %b cyc %0d", tag, locked, e.lock, cyc);
        end
    endtask

    task automatic step(string tag);
        model_push();
        @(posedge clk_in);
        #1;
        cyc++;
        pop_check(tag);
        cfg_load = 1'b0;
        if (pix_tick === 1'b1) begin
            if (cyc - last_tick < min_gap) min_gap = cyc - last_tick;
            if (cyc - last_tick == 5) saw5 = 1'b1;
            last_tick = cyc;
            tick_cnt++;
        end
    endtask

    task automatic run(int n, string tag);
        repeat (n) step(tag);
    endtask

    task automatic load(bit m, int unsigned d, longint unsigned i, string tag);
        cfg_mode = m;
        cfg_div  = DIV_W'(d);
        cfg_inc  = ACC_W'(i);
        cfg_load = 1'b1;
        step(tag);
    endtask

    task automatic chk(string tag, logic got, logic exp_v);
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL %s: got %b exp %b", tag, got, exp_v);
        end
    endtask

    task automatic seg_start();
        tick_cnt  = 0;
        min_gap   = 1000;
        last_tick = cyc;
        saw5      = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        sb.push_back('0);
        pop_check("reset");
        reset = 1'b0;

        // Integer divide-by-4, applied while disabled
        load(1'b0, 4, 0, "ld4");
        step("apply4");
        en = 1'b1;
        seg_start();
        run(70, "div4");
        checks++;
        assert (tick_cnt == 17) else begin
            errors++;
            $error("FAIL div4_ticks: got %0d exp 17", tick_cnt);
        end
        chk("div4_lock", locked, 1'b1);

        // Mid-period reload to 6
        load(1'b0, 6, 0, "ld6");
        chk("ld6_unlock", locked, 1'b0);
        run(60, "div6");

        // Two loads before the boundary: last one wins
        seg_start();
        load(1'b0, 5, 0, "ld5");
        load(1'b0, 3, 0, "ld3");
        run(40, "div3");
        chk("no_gap5", saw5, 1'b0);

        // Divisor 0 and 1 both mean divide-by-1
        load(1'b0, 0, 0, "ld0");
        run(30, "div0");
        chk("div0_tick", pix_tick, 1'b1);
        chk("div0_clk", clk_pix, 1'b1);
        load(1'b0, 1, 0, "ld1");
        run(30, "div1");
        chk("div1_lock", locked, 1'b1);

        // Zero increment never ticks and never locks
        seg_start();
        load(1'b1, 0, 0, "ldinc0");
        run(40, "inc0");
        chk("inc0_lock", locked, 1'b0);

        // Default fractional increment over a long window
        en = 1'b0;
        load(1'b1, 0, DINC, "ldfrac");
        step("applyfrac");
        en = 1'b1;
        seg_start();
        run(20000, "frac");
        ref_cnt = (64'd20000 * DINC) >> 32;
        checks++;
        assert (tick_cnt >= int'(ref_cnt) - 1 && tick_cnt <= int'(ref_cnt) + 1) else begin
            errors++;
            $error("FAIL frac_count: got %0d exp %0d", tick_cnt, ref_cnt);
        end
        checks++;
        assert (min_gap >= 3) else begin
            errors++;
            $error("FAIL frac_gap: got %0d exp >=3", min_gap);
        end
        chk("frac_lock", locked, 1'b1);

        // Enable dropped mid-period, then resumed
        en = 1'b0;
        load(1'b0, 7, 0, "ld7");
        step("apply7");
        en = 1'b1;
        run(10, "div7a");
        en = 1'b0;
        run(10, "div7off");
        en = 1'b1;
        run(20, "div7b");

        // Asynchronous reset with a pending config
        load(1'b0, 9, 0, "ld9");
        run(1, "pend9");
        #3;
        reset = 1'b1;
        #1;
        sb.push_back('0);
        pop_check("async_rst");
        model_reset();
        #20;
        reset = 1'b0;
        seg_start();
        run(40, "deflt");
        ref_cnt = (64'd40 * DINC) >> 32;
        checks++;
        assert (tick_cnt == int'(ref_cnt)) else begin
            errors++;
            $error("FAIL deflt_ticks: got %0d exp %0d", tick_cnt, ref_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
